// File: rtl/tx_interface.sv
// Return path of the UART calculator: converts a latched 8-bit ALU result to
// decimal ASCII and streams the digits plus a terminator byte to uart_tx.
module tx_interface #(
    parameter int         DBIT      = 8,
    parameter logic [7:0] END_CHAR  = 8'd10,
    parameter bit         LEAD_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DBIT-1:0] result,
    input  logic            tx_done_tick,
    output logic [7:0]      din,
    output logic            tx_start,
    output logic            rd,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LOAD,
        WAIT_DONE,
        ACK,
        REARM
    } state_t;

    state_t     state_q, state_n;
    logic [7:0] value_q, value_n;
    logic [1:0] hund_q, hund_n;
    logic [3:0] tens_q, tens_n;
    logic [3:0] ones_q, ones_n;
    logic [1:0] pos_q, pos_n;
    logic [7:0] din_n;
    logic       tx_start_n;
    logic       rd_n;
    logic       busy_n;

    // Sequence positions: 0 = hundreds, 1 = tens, 2 = ones, 3 = terminator.
    function automatic logic [7:0] seq_byte(input logic [1:0] pos,
                                            input logic [1:0] h,
                                            input logic [3:0] t,
                                            input logic [3:0] o);
        logic [7:0] b;
        case (pos)
            2'd0:    b = 8'd48 + {6'd0, h};
            2'd1:    b = 8'd48 + {4'd0, t};
            2'd2:    b = 8'd48 + {4'd0, o};
            default: b = END_CHAR;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] first_pos(input logic [1:0] h,
                                             input logic [3:0] t);
        logic [1:0] p;
        if (LEAD_ZERO || h != 2'd0) begin
            p = 2'd0;
        end else if (t != 4'd0) begin
            p = 2'd1;
        end else begin
            p = 2'd2;
        end
        return p;
    endfunction

    always_comb begin
        state_n    = state_q;
        value_n    = value_q;
        hund_n     = hund_q;
        tens_n     = tens_q;
        ones_n     = ones_q;
        pos_n      = pos_q;
        din_n      = din;
        tx_start_n = 1'b0;
        rd_n       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    value_n = 8'(result);
                    hund_n  = 2'd0;
                    tens_n  = 4'd0;
                    ones_n  = 4'd0;
                    pos_n   = 2'd0;
                    state_n = CONV;
                end
            end
            // Repeated subtraction, one step per cycle; the final step
            // already prepares the first byte so tx_start is registered.
            CONV: begin
                if (value_q >= 8'd100) begin
                    value_n = value_q - 8'd100;
                    hund_n  = hund_q + 2'd1;
                end else if (value_q >= 8'd10) begin
                    value_n = value_q - 8'd10;
                    tens_n  = tens_q + 4'd1;
                end else begin
                    ones_n     = value_q[3:0];
                    pos_n      = first_pos(hund_q, tens_q);
                    din_n      = seq_byte(pos_n, hund_q, tens_q, value_q[3:0]);
                    tx_start_n = 1'b1;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    if (pos_q == 2'd3) begin
                        rd_n    = 1'b1;
                        state_n = ACK;
                    end else begin
                        pos_n      = pos_q + 2'd1;
                        din_n      = seq_byte(pos_n, hund_q, tens_q, ones_q);
                        tx_start_n = 1'b1;
                        state_n    = LOAD;
                    end
                end
            end
            ACK: begin
                state_n = REARM;
            end
            REARM: begin
                if (!start) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            value_q  <= 8'd0;
            hund_q   <= 2'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            pos_q    <= 2'd0;
            din      <= 8'd0;
            tx_start <= 1'b0;
            rd       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            value_q  <= value_n;
            hund_q   <= hund_n;
            tens_q   <= tens_n;
            ones_q   <= ones_n;
            pos_q    <= pos_n;
            din      <= din_n;
            tx_start <= tx_start_n;
            rd       <= rd_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_tx_interface.sv
// Scoreboard bench for tx_interface: two instances (leading zeros kept and
// suppressed) share one stimulus path selected by sel.
module tb_tx_interface;

    localparam int RD_EVENT = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] result;
    logic       tx_done_tick;
    logic       sel;

    logic       start0, start1, done0, done1;
    logic [7:0] din0, din1, din_m;
    logic       txs0, txs1, txs_m;
    logic       rd0, rd1, rd_m;
    logic       busy0, busy1, busy_m;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int last_exp = -1;
    logic prev_tx = 1'b0;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign done0  = tx_done_tick & ~sel;
    assign done1  = tx_done_tick & sel;
    assign din_m  = sel ? din1 : din0;
    assign txs_m  = sel ? txs1 : txs0;
    assign rd_m   = sel ? rd1 : rd0;
    assign busy_m = sel ? busy1 : busy0;

    tx_interface #(.DBIT(8), .END_CHAR(8'd10), .LEAD_ZERO(1'b1)) dut_lz (
        .clk(clk), .reset(reset), .start(start0), .result(result),
        .tx_done_tick(done0), .din(din0), .tx_start(txs0), .rd(rd0), .busy(busy0)
    );

    tx_interface #(.DBIT(8), .END_CHAR(8'd10), .LEAD_ZERO(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .start(start1), .result(result),
        .tx_done_tick(done1), .din(din1), .tx_start(txs1), .rd(rd1), .busy(busy1)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the selected DUT emits a byte or rd.
    always begin : monitor
        int e;
        @(posedge clk);
        #1;
        if (reset) begin
            if (txs_m) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = -1;
                checkOutput("din_byte", int'(din_m), e);
                checkOutput("tx_start_width", int'(prev_tx), 0);
                last_exp = e;
            end
            if (rd_m) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = -1;
                checkOutput("rd_order", RD_EVENT, e);
            end
            checkOutput("idle_dut_tx_start", int'(sel ? txs0 : txs1), 0);
        end
        prev_tx = txs_m;
    end

    task automatic runHandshakes(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!txs_m && w < 60) begin
                @(negedge clk);
                w++;
            end
            checkOutput("tx_start_seen", int'(txs_m), 1);
            if (!txs_m) return;
            repeat (10) @(negedge clk);
            checkOutput("din_hold", int'(din_m), last_exp);
            checkOutput("busy_during", int'(busy_m), 1);
            tx_done_tick = 1'b1;
            @(negedge clk);
            tx_done_tick = 1'b0;
        end
    endtask

    task automatic finishCommand(input int hold);
        int w = 0;
        while (!rd_m && w < 30) begin
            @(negedge clk);
            w++;
        end
        checkOutput("rd_seen", int'(rd_m), 1);
        @(negedge clk);
        checkOutput("rd_single", int'(rd_m), 0);
        checkOutput("busy_after_rd", int'(busy_m), 1);
        repeat (hold) @(negedge clk);
        if (hold > 0) checkOutput("busy_held", int'(busy_m), 1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_idle", int'(busy_m), 0);
        checkOutput("queue_drained", exp_q.size(), 0);
    endtask

    task automatic applyStimulus(input logic which, input int value, input int alt,
                                 input bit spur, input int exp_conv, input int n,
                                 input int b0, input int b1, input int b2, input int b3,
                                 input int hold);
        int bb[4];
        int cyc = 0;
        bb = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) exp_q.push_back(bb[i]);
        exp_q.push_back(RD_EVENT);
        @(negedge clk);
        sel    = which;
        result = 8'(value);
        start  = 1'b1;
        while (!txs_m && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) result = 8'(alt);
            tx_done_tick = (spur && cyc == 2);
        end
        tx_done_tick = 1'b0;
        if (exp_conv > 0) checkOutput("conv_latency", cyc, exp_conv);
        runHandshakes(n);
        finishCommand(hold);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int w;
        reset        = 1'b0;
        start        = 1'b0;
        result       = 8'd0;
        tx_done_tick = 1'b0;
        sel          = 1'b0;
        #12;
        checkOutput("reset_din", int'(din0), 0);
        checkOutput("reset_tx_start", int'(txs0), 0);
        checkOutput("reset_rd", int'(rd0), 0);
        checkOutput("reset_busy", int'(busy0), 0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        @(negedge clk);
        checkOutput("idle_spur_busy", int'(busy0), 0);
        checkOutput("idle_spur_tx_start", int'(txs0), 0);

        applyStimulus(1'b0, 123, 123, 1'b1, 5, 4, 49, 50, 51, 10, 0);
        applyStimulus(1'b0, 255, 0,   1'b0, 9, 4, 50, 53, 53, 10, 0);
        applyStimulus(1'b0, 0,   0,   1'b0, 2, 4, 48, 48, 48, 10, 0);
        applyStimulus(1'b1, 0,   0,   1'b0, 2, 2, 48, 10, 0, 0, 0);
        applyStimulus(1'b1, 7,   7,   1'b0, 2, 2, 55, 10, 0, 0, 0);
        applyStimulus(1'b1, 105, 105, 1'b0, 3, 4, 49, 48, 53, 10, 0);
        applyStimulus(1'b1, 30,  30,  1'b0, 0, 3, 51, 48, 10, 0, 0);
        applyStimulus(1'b0, 77,  77,  1'b0, 0, 4, 48, 55, 55, 10, 200);
        applyStimulus(1'b0, 42,  42,  1'b0, 0, 4, 48, 52, 50, 10, 0);

        // Abort in wait_done after the second byte, then restart fresh.
        exp_q.push_back(50);
        exp_q.push_back(48);
        @(negedge clk);
        sel    = 1'b0;
        result = 8'd200;
        start  = 1'b1;
        runHandshakes(1);
        w = 0;
        while (!txs0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        checkOutput("second_tx_start", int'(txs0), 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_din", int'(din0), 0);
        checkOutput("abort_tx_start", int'(txs0), 0);
        checkOutput("abort_rd", int'(rd0), 0);
        checkOutput("abort_busy", int'(busy0), 0);
        checkOutput("queue_after_abort", exp_q.size(), 0);
        result = 8'd9;
        exp_q.push_back(48);
        exp_q.push_back(48);
        exp_q.push_back(57);
        exp_q.push_back(10);
        exp_q.push_back(RD_EVENT);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        runHandshakes(4);
        finishCommand(0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_interface.md
Name: tx_interface

Overview:
- Return path of the UART calculator: when the operand/opcode parser signals a complete command, this block latches the 8-bit ALU result and converts it to decimal ASCII.
- It streams the digits plus a terminator byte to the UART transmitter, one byte per tx_start/tx_done_tick handshake.
- It then pulses rd so the parser releases its rx_empty flag.
- Sits between ALU output / parser and uart_tx.

Parameters:
- DBIT, 8, width of result input and of din output. The block is fixed at 8; other values are unsupported.
- END_CHAR, 10, ASCII code sent after the last digit (LF).
- LEAD_ZERO, 1, 1 = always send 3 digits; 0 = suppress leading zeros, always at least one digit.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  level from parser (rx_empty): command complete, result valid
- result  input  DBIT  ALU result, unsigned 0..255
- tx_done_tick  input  1  one-cycle pulse from uart_tx: current byte fully sent
- din  output  8  byte to uart_tx
- tx_start  output  1  one-cycle pulse: uart_tx should load din
- rd  output  1  one-cycle pulse to parser: result consumed
- busy  output  1  high from leaving idle until return to idle

Behaviour:
- Reset (reset=0, asynchronous): state=idle; din=0, tx_start=0, rd=0, busy=0; value, digit and index registers cleared. Reset mid-transfer aborts immediately, with no rd pulse. After release, the block behaves as from power-up.
- All outputs are registered. tx_start and rd are never high for more than one cycle.
- idle: on start=1, latch result into value, clear hundreds/tens, set busy=1, go to conv. result changes after latch are ignored.
- conv: one subtraction per cycle.
  - If value>=100: value-=100, hundreds++.
  - Else if value>=10: value-=10, tens++.
  - Else: ones=value; go to load.
  - Worst case (255): 2+5+1=8 cycles in conv.
- Byte sequence:
  - LEAD_ZERO=1: H,T,O,END_CHAR.
  - LEAD_ZERO=0: H only if hundreds!=0; T only if hundreds!=0 or tens!=0; O always; then END_CHAR.
  - Digit byte = 48 + digit.
- load: drive din with next byte of sequence, pulse tx_start=1 for exactly this one cycle, go to wait_done. din must stay stable until tx_done_tick.
- wait_done: on tx_done_tick:
  - If more bytes remain, go to load; the next tx_start comes one cycle after tx_done_tick.
  - After END_CHAR, go to ack.
- tx_done_tick in any state other than wait_done is ignored.
- ack: pulse rd=1 for one cycle, go to rearm.
- rearm: stay until start=0, then go to idle with busy=0. Exactly one transmission occurs per rising assertion of start; start held high never retriggers.
- start falling while in conv/load/wait_done is ignored; the transfer completes.
- Total bytes: 4 when LEAD_ZERO=1; 2..4 when LEAD_ZERO=0.

Test Plan:
- result=123, start held, tx_done_tick 10 cycles after each tx_start -> din sequence 49,50,51,10; four tx_start pulses; one rd pulse after the 4th tx_done_tick; busy returns 0 only after start drops.
- result=255, LEAD_ZERO=1 -> 50,53,53,10; conv takes 8 cycles; result changed to 0 mid-transfer has no effect.
- result=0: LEAD_ZERO=1 -> 48,48,48,10; LEAD_ZERO=0 -> 48,10. result=7, LEAD_ZERO=0 -> 55,10. result=105, LEAD_ZERO=0 -> 49,48,53,10.
- Spurious tx_done_tick in idle and in conv -> no tx_start, no state change. start held high 200 cycles after rd -> no second transmission; drop start, reassert with result=42 -> 48,52,50,10.
- reset=0 asserted while in wait_done after the 2nd byte -> outputs 0 within the same cycle, no rd; after release with start=1, result=9 -> full fresh sequence 48,48,57,10.
